lcrc_32_stream: RTL

Parametrised streaming LCRC-32 generator for the data-link transmit path. It accepts a TLP as a framed stream of DATA_W-bit beats and forwards each beat unchanged. After the last beat it appends the 32-bit LCRC as 32/DATA_W extra beats. It sits between the TLP source and the replay buffer write port, so the replay buffer always stores CRC-protected frames.

---
 rtl/lcrc_pkg.sv | 14 +
 rtl/lcrc_32_step.sv | 25 ++
 rtl/lcrc_32_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lcrc_pkg.sv
// LCRC-32 shared constants and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lcrc_pkg;

  localparam logic [31:0] LCRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] LCRC_INIT = 32'hFFFFFFFF;

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

endpackage

// File: rtl/lcrc_32_step.sv
// One-beat LCRC-32 register update, MSB-first, unrolled bit-serial.
// Latency: combinational.
// Backpressure: none; caller decides when to commit crc_out.
module lcrc_32_step
  import lcrc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_out
);

  logic [31:0] c;

  // Shift each data bit in from the MSB, feeding back the polynomial.
  always_comb begin
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ (((c[31] ^ data[i]) == 1'b1) ? LCRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/lcrc_32_stream.sv
// Streaming LCRC-32 appender: forwards TLP beats, then appends 32/DATA_W LCRC beats.
// Latency: one cycle input-to-output through a single output register; optional
// LCRC_32_ERR_INJECT_EN adds inject_err. Backpressure: in_ready = slot free in PASS, 0 in APPEND.
module lcrc_32_stream
  import lcrc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef LCRC_32_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              out_is_crc,
  output logic [31:0]       crc_value,
  output logic              busy
);

  localparam int          CRC_BEATS = 32 / DATA_W;
  localparam logic [1:0]  LAST_CNT  = 2'(CRC_BEATS - 1);

  generate
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
      $error("lcrc_32_stream: DATA_W must be 8, 16 or 32");
    end
  endgenerate

  state_t      state, state_next;
  logic [31:0] crc_reg;
  logic [31:0] crc_step;
  logic [31:0] hold;      // finished LCRC, shifted left as chunks are emitted
  logic [31:0] inj_mask;
  logic [1:0]  count;
  logic        slot_free;
  logic        in_xfer;
  logic        chunk_load;
  logic        chunk_last;

`ifdef LCRC_32_ERR_INJECT_EN
  assign inj_mask = {31'h0, inject_err};
`else
  assign inj_mask = 32'h0;
`endif

  lcrc_32_step #(.DATA_W(DATA_W)) u_step (
    .crc_in  (crc_reg),
    .data    (in_data),
    .crc_out (crc_step)
  );

  // Next-state and handshake decode.
  always_comb begin
    slot_free  = !out_valid || out_ready;
    chunk_last = (count == LAST_CNT);
    in_ready   = 1'b0;
    in_xfer    = 1'b0;
    chunk_load = 1'b0;
    state_next = state;
    case (state)
      PASS: begin
        in_ready = slot_free;
        in_xfer  = in_valid && slot_free;
        if (in_xfer && in_last) state_next = APPEND;
      end
      APPEND: begin
        chunk_load = slot_free;
        if (slot_free && chunk_last) state_next = PASS;
      end
      default: state_next = PASS;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PASS;
    else          state <= state_next;
  end

  // Output register, CRC accumulator and LCRC hold/chunk counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_is_crc <= 1'b0;
      crc_reg    <= LCRC_INIT;
      hold       <= 32'h0;
      crc_value  <= 32'h0;
      count      <= 2'd0;
    end else if (in_xfer) begin
      out_data   <= in_data;
      out_valid  <= 1'b1;
      out_is_crc <= 1'b0;
      out_last   <= 1'b0;
      crc_reg    <= crc_step;
      if (in_last) begin
        hold      <= ~crc_step ^ inj_mask;
        crc_value <= ~crc_step;
        count     <= 2'd0;
      end
    end else if (chunk_load) begin
      out_data   <= hold[31 -: DATA_W];
      hold       <= hold << DATA_W;
      out_valid  <= 1'b1;
      out_is_crc <= 1'b1;
      out_last   <= chunk_last;
      count      <= count + 2'd1;
      if (chunk_last) begin
        count   <= 2'd0;
        crc_reg <= LCRC_INIT;
      end
    end else if (slot_free) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_is_crc <= 1'b0;
    end
  end

  // Frame-in-progress flag: first accepted beat until the final LCRC chunk leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                busy <= 1'b0;
    else if (in_xfer)                            busy <= 1'b1;
    else if (out_valid && out_ready && out_last) busy <= 1'b0;
  end

endmodule
